load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter Address_Width, default 32, byte-address width.
REQ-002 Parameter REG_Width, default 32, data word width.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 REQ  in  1  access request from core this cycle.
REQ-006 WR  in  1  1 = store, 0 = load.
REQ-007 SIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SIGNED  in  1  1 = sign-extend sub-word load, 0 = zero-extend.
REQ-009 ADDR  in  Address_Width  byte address from ALU.
REQ-010 WDATA  in  REG_Width  store data (rt), right-aligned.
REQ-011 RDATA  out  REG_Width  aligned, extended load result.
REQ-012 STALL  out  1  core holds PC and request while high.
REQ-013 ERR  out  1  one-cycle pulse on misaligned or illegal access.
REQ-014 ERR_ADDR  out  Address_Width  byte address of last faulting access.
REQ-015 MEM_A  out  Address_Width  word index to data memory (ADDR >> 2).
REQ-016 MEM_WD  out  REG_Width  write word to data memory.
REQ-017 MEM_WE  out  1  data memory write enable.
REQ-018 MEM_RD  in  REG_Width  combinational read word from data memory.

Function
REQ-019 Byte lanes SHALL be little-endian: offset ADDR[1:0]=k selects bits [8k+7:8k].
REQ-020 Misaligned SHALL mean SIZE=01 with ADDR[0]=1, SIZE=10 with ADDR[1:0]!=00, or SIZE=11.
REQ-021 FSM states SHALL be IDLE and MERGE only.
REQ-022 IDLE, REQ=1, misaligned: ERR=1 same cycle, MEM_WE=0, STALL=0, ERR_ADDR<=ADDR on edge, state stays IDLE.
REQ-023 IDLE, aligned load: MEM_A=ADDR>>2, RDATA from MEM_RD same cycle (zero latency), STALL=0, MEM_WE=0.
REQ-024 Load byte/half SHALL extract the addressed lane and extend to REG_Width per SIGNED; word load passes MEM_RD unchanged.
REQ-025 IDLE, aligned word store: MEM_WE=1, MEM_WD=WDATA, MEM_A=ADDR>>2 same cycle, STALL=0.
REQ-026 IDLE, aligned byte/half store: STALL=1, MEM_WE=0, MEM_A=ADDR>>2; on edge capture MEM_RD, ADDR, WDATA, SIZE; go MERGE.
REQ-027 MERGE: MEM_A from captured address, MEM_WD = captured old word with only addressed lane(s) replaced by low bits of captured WDATA, MEM_WE=1, STALL=0; next state IDLE.
REQ-028 In MERGE all core inputs SHALL be ignored; ERR SHALL be 0.
REQ-029 REQ=0 in IDLE: MEM_WE=0, STALL=0, ERR=0, RDATA=0.
REQ-030 Every sub-word store SHALL take exactly 2 cycles; every other access exactly 1.
REQ-031 MEM_WE SHALL never be 1 in a cycle where ERR=1.

Reset
REQ-032 RST low SHALL force IDLE, clear capture registers and ERR_ADDR to 0, and drive MEM_WE=0, STALL=0, ERR=0 asynchronously.
REQ-033 Reset during MERGE SHALL abandon the pending store; memory is not written.
REQ-034 After RST release, the first rising edge SHALL accept a new request normally.

Structure
REQ-035 Shared package lsu_pkg SHALL hold SIZE encodings, FSM state type, and the byte-lane mask constants.
REQ-036 Sub-module lsu_load_align (combinational lane extract + extend) SHALL be instantiated once; merge logic stays in the top.
REQ-037 Total RTL SHALL be 120-400 lines.

Verification
REQ-038 Reset, SW ADDR=0x8 WDATA=0xDEADBEEF -> same cycle MEM_A=2, MEM_WE=1, MEM_WD=0xDEADBEEF, STALL=0.
REQ-039 MEM_RD=0x80FF1234, LB ADDR=0x3 SIGNED=1 -> RDATA=0xFFFFFF80; SIGNED=0 -> 0x00000080.
REQ-040 MEM_RD=0x11223344, SB ADDR=0x5 WDATA=0xAA -> cycle1 STALL=1 MEM_WE=0; cycle2 MEM_A=1 MEM_WE=1 MEM_WD=0x1122AA44.
REQ-041 SH ADDR=0x3 -> ERR=1 one cycle, MEM_WE=0, ERR_ADDR=0x3 next cycle; SIZE=11 ADDR=0x0 -> ERR=1.
REQ-042 SH ADDR=0x2 started, RST low during MERGE -> MEM_WE=0, STALL=0, memory word unchanged, state IDLE.
REQ-043 MEM_RD=0x80001234, LH ADDR=0x2 SIGNED=1 -> RDATA=0xFFFF8000; ADDR=0x0 SIGNED=0 -> 0x00001234.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SzByte    = 2'b00,
    SzHalf    = 2'b01,
    SzWord    = 2'b10,
    SzIllegal = 2'b11
  } size_e;

  typedef enum logic {
    StIdle  = 1'b0,
    StMerge = 1'b1
  } state_e;

  localparam logic [3:0] ByteMask = 4'b0001;
  localparam logic [3:0] HalfMask = 4'b0011;
  localparam logic [3:0] WordMask = 4'b1111;

  function automatic logic is_misaligned(size_e size, logic [1:0] off);
    logic mis;
    case (size)
      SzByte:  mis = 1'b0;
      SzHalf:  mis = off[0];
      SzWord:  mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Byte lanes touched by an aligned access at offset off.
  function automatic logic [3:0] lane_mask(size_e size, logic [1:0] off);
    logic [3:0] mask;
    case (size)
      SzByte:  mask = ByteMask << off;
      SzHalf:  mask = HalfMask << off;
      default: mask = WordMask;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed little-endian lane of a read word and sign/zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] rd_i,
  input  size_e            size_i,
  input  logic             sign_i,
  input  logic [1:0]       off_i,
  output logic [Width-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rd_i[{off_i, 3'b000} +: 8];
  assign half_lane = rd_i[{off_i[1], 4'b0000} +: 16];

  always_comb begin
    case (size_i)
      SzByte:  data_o = {{(Width - 8){sign_i & byte_lane[7]}}, byte_lane};
      SzHalf:  data_o = {{(Width - 16){sign_i & half_lane[15]}}, half_lane};
      default: data_o = rd_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-cycle loads and word stores, two-cycle read-merge-write
// for sub-word stores, and a one-cycle error pulse on misaligned/illegal accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned Address_Width = 32,
  parameter int unsigned REG_Width     = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     REQ,
  input  logic                     WR,
  input  logic [1:0]               SIZE,
  input  logic                     SIGNED,
  input  logic [Address_Width-1:0] ADDR,
  input  logic [REG_Width-1:0]     WDATA,
  output logic [REG_Width-1:0]     RDATA,
  output logic                     STALL,
  output logic                     ERR,
  output logic [Address_Width-1:0] ERR_ADDR,
  output logic [Address_Width-1:0] MEM_A,
  output logic [REG_Width-1:0]     MEM_WD,
  output logic                     MEM_WE,
  input  logic [REG_Width-1:0]     MEM_RD
);

  state_e                   state_q, state_d;
  size_e                    size_q;
  logic [REG_Width-1:0]     old_q, wdata_q;
  logic [Address_Width-1:0] addr_q, err_addr_q;

  size_e                size_in;
  logic                 misalign;
  logic [REG_Width-1:0] load_data;
  logic [REG_Width-1:0] shifted, merged;
  logic [3:0]           mask;

  assign size_in  = size_e'(SIZE);
  assign misalign = is_misaligned(size_in, ADDR[1:0]);
  assign ERR_ADDR = err_addr_q;

  lsu_load_align #(
    .Width (REG_Width)
  ) u_load_align (
    .rd_i   (MEM_RD),
    .size_i (size_in),
    .sign_i (SIGNED),
    .off_i  (ADDR[1:0]),
    .data_o (load_data)
  );

  // Old word with only the addressed lanes replaced by the shifted store data.
  always_comb begin
    shifted = wdata_q << {addr_q[1:0], 3'b000};
    mask    = lane_mask(size_q, addr_q[1:0]);
    merged  = old_q;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = shifted[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    MEM_A   = ADDR >> 2;
    MEM_WD  = WDATA;
    MEM_WE  = 1'b0;
    STALL   = 1'b0;
    ERR     = 1'b0;
    RDATA   = '0;
    case (state_q)
      StIdle: begin
        if (REQ) begin
          if (misalign) begin
            ERR = 1'b1;
          end else if (!WR) begin
            RDATA = load_data;
          end else if (size_in == SzWord) begin
            MEM_WE = 1'b1;
          end else begin
            STALL   = 1'b1;
            state_d = StMerge;
          end
        end
      end
      StMerge: begin
        MEM_A   = addr_q >> 2;
        MEM_WD  = merged;
        MEM_WE  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset must silence the memory and core handshake without waiting for a clock.
    if (!RST) begin
      MEM_WE = 1'b0;
      STALL  = 1'b0;
      ERR    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      size_q     <= SzByte;
      old_q      <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && REQ) begin
        if (misalign) begin
          err_addr_q <= ADDR;
        end else if (WR && size_in != SzWord) begin
          old_q   <= MEM_RD;
          addr_q  <= ADDR;
          wdata_q <= WDATA;
          size_q  <= size_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 16-word memory model and an expectation queue.
module tb_load_store_unit;

  typedef enum {SigRdata, SigStall, SigErr, SigErrAddr, SigMemA, SigMemWd, SigMemWe, SigMem} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    int          idx;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr, sgn;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata, err_addr, mem_a, mem_wd, mem_rd;
  logic        stall, err, mem_we;

  logic [31:0] mem [16];
  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[3:0]];

  load_store_unit #(
    .Address_Width (32),
    .REG_Width     (32)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .REQ      (req),
    .WR       (wr),
    .SIZE     (size),
    .SIGNED   (sgn),
    .ADDR     (addr),
    .WDATA    (wdata),
    .RDATA    (rdata),
    .STALL    (stall),
    .ERR      (err),
    .ERR_ADDR (err_addr),
    .MEM_A    (mem_a),
    .MEM_WD   (mem_wd),
    .MEM_WE   (mem_we),
    .MEM_RD   (mem_rd)
  );

  function automatic logic [31:0] observe(sig_e s, int idx);
    logic [3:0] i;
    i = idx[3:0];
    case (s)
      SigRdata:   return rdata;
      SigStall:   return {31'b0, stall};
      SigErr:     return {31'b0, err};
      SigErrAddr: return err_addr;
      SigMemA:    return mem_a;
      SigMemWd:   return mem_wd;
      SigMemWe:   return {31'b0, mem_we};
      default:    return mem[i];
    endcase
  endfunction

  task automatic expect_v(input string tag, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sig = s; e.idx = 0; e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_mem(input string tag, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sig = SigMem; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.sig, e.idx);
      checks++;
      assert (got === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; wr = w; size = s; sgn = sg; addr = a; wdata = d;
    #2;
  endtask

  // Commit the write presented this cycle to the memory model, then move to the next negedge.
  task automatic tick();
    logic        we;
    logic [31:0] a, d;
    we = mem_we; a = mem_a; d = mem_wd;
    @(posedge clk);
    #1;
    if (we) mem[a[3:0]] = d;
    @(negedge clk);
  endtask

  task automatic step();
    drain();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst = 1'b0;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
    @(negedge clk);
    #2;
    expect_v("rst_we", SigMemWe, 32'd0);
    expect_v("rst_stall", SigStall, 32'd0);
    expect_v("rst_err", SigErr, 32'd0);
    expect_v("rst_err_addr", SigErrAddr, 32'd0);
    drain();

    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
    expect_v("sw_mem_a", SigMemA, 32'd2);
    expect_v("sw_we", SigMemWe, 32'd1);
    expect_v("sw_wd", SigMemWd, 32'hDEADBEEF);
    expect_v("sw_stall", SigStall, 32'd0);
    expect_v("sw_err", SigErr, 32'd0);
    step();

    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    expect_mem("sw_mem2", 2, 32'hDEADBEEF);
    expect_v("lw_rdata", SigRdata, 32'hDEADBEEF);
    expect_v("lw_we", SigMemWe, 32'd0);
    step();

    mem[0] = 32'h80FF1234;
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
    expect_v("lb_s_rdata", SigRdata, 32'hFFFFFF80);
    expect_v("lb_s_mem_a", SigMemA, 32'd0);
    expect_v("lb_s_stall", SigStall, 32'd0);
    step();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
    expect_v("lb_u_rdata", SigRdata, 32'h00000080);
    step();

    mem[0] = 32'h80001234;
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
    expect_v("lh_s_rdata", SigRdata, 32'hFFFF8000);
    step();
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
    expect_v("lh_u_rdata", SigRdata, 32'h00001234);
    step();

    mem[1] = 32'h11223344;
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h5, 32'h000000AA);
    expect_v("sb_c1_stall", SigStall, 32'd1);
    expect_v("sb_c1_we", SigMemWe, 32'd0);
    expect_v("sb_c1_mem_a", SigMemA, 32'd1);
    expect_v("sb_c1_err", SigErr, 32'd0);
    step();
    // Core inputs during the merge cycle must have no effect.
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
    expect_v("sb_c2_mem_a", SigMemA, 32'd1);
    expect_v("sb_c2_we", SigMemWe, 32'd1);
    expect_v("sb_c2_wd", SigMemWd, 32'h1122AA44);
    expect_v("sb_c2_stall", SigStall, 32'd0);
    expect_v("sb_c2_err", SigErr, 32'd0);
    step();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
    expect_v("idle_we", SigMemWe, 32'd0);
    expect_v("idle_stall", SigStall, 32'd0);
    expect_v("idle_rdata", SigRdata, 32'd0);
    expect_mem("sb_mem1", 1, 32'h1122AA44);
    step();

    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h6, 32'h5566BEEF);
    expect_v("sh_c1_stall", SigStall, 32'd1);
    step();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    expect_v("sh_c2_wd", SigMemWd, 32'hBEEFAA44);
    expect_v("sh_c2_we", SigMemWe, 32'd1);
    step();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    expect_mem("sh_mem1", 1, 32'hBEEFAA44);
    step();

    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h3, 32'h1234);
    expect_v("mis_sh_err", SigErr, 32'd1);
    expect_v("mis_sh_we", SigMemWe, 32'd0);
    expect_v("mis_sh_stall", SigStall, 32'd0);
    step();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    expect_v("mis_err_pulse", SigErr, 32'd0);
    expect_v("mis_err_addr", SigErrAddr, 32'h3);
    step();
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    expect_v("ill_err", SigErr, 32'd1);
    expect_v("ill_rdata", SigRdata, 32'd0);
    step();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h6, 32'hFFFFFFFF);
    expect_v("mis_sw_err", SigErr, 32'd1);
    expect_v("mis_sw_we", SigMemWe, 32'd0);
    step();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    expect_v("mis_sw_err_addr", SigErrAddr, 32'h6);
    step();

    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h2, 32'h5678);
    expect_v("rm_c1_stall", SigStall, 32'd1);
    step();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    expect_v("rm_c2_wd", SigMemWd, 32'h56781234);
    expect_v("rm_c2_we", SigMemWe, 32'd1);
    drain();
    rst = 1'b0;
    #1;
    expect_v("rm_rst_we", SigMemWe, 32'd0);
    expect_v("rm_rst_stall", SigStall, 32'd0);
    expect_v("rm_rst_err", SigErr, 32'd0);
    step();
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    expect_mem("rm_mem0", 0, 32'h80001234);
    expect_v("rm_err_addr", SigErrAddr, 32'd0);
    expect_v("rm_idle_stall", SigStall, 32'd0);
    step();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    expect_v("post_rst_rdata", SigRdata, 32'h80001234);
    expect_v("post_rst_stall", SigStall, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
